// File: rtl/simon_pkt_serialiser.sv
// Packet-to-byte serialiser behind the SIMON packet core.
// Captures whole packets from the core's parallel bus into a two-slot
// ping-pong store and streams each one out a byte per beat, byte 0 first.
module simon_pkt_serialiser #(
    parameter int unsigned N         = 96,
    parameter int unsigned PKT_BYTES = (N / 2) + 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   R,
    input  logic [PKT_BYTES*8-1:0] out,
    input  logic                   out_donePKT,
    output logic                   out_readPKT,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_last,
    output logic                   busy,
    output logic [CNT_W-1:0]       pkt_count
);

    localparam int unsigned PktW = PKT_BYTES * 8;
    localparam int unsigned IdxW = $clog2(PKT_BYTES);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(PKT_BYTES - 1);

    typedef enum logic {
        CIdle,
        CAck
    } cap_state_e;

    cap_state_e       cap_q, cap_d;
    logic [PktW-1:0]  slot_q [2];
    logic [1:0]       occ_q, occ_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             readpkt_q, readpkt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_last_q, tx_last_d;

    logic             capture;
    logic             beat;
    logic [PktW-1:0]  sel_pkt;

    // Capture handshake, drain bookkeeping and the next-cycle output byte.
    always_comb begin
        cap_d    = cap_q;
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        beat     = tx_valid_q & tx_ready;

        unique case (cap_q)
            CIdle: begin
                // Occupancy is the pre-edge value: a slot freed this edge waits a cycle.
                if (out_donePKT && !occ_q[wr_ptr_q]) begin
                    capture         = 1'b1;
                    occ_d[wr_ptr_q] = 1'b1;
                    wr_ptr_d        = ~wr_ptr_q;
                    cap_d           = CAck;
                end
            end
            CAck: begin
                // Only return to idle once the core has dropped its request.
                if (!out_donePKT) begin
                    cap_d = CIdle;
                end
            end
            default: cap_d = CIdle;
        endcase

        if (beat) begin
            if (idx_q == LastIdx) begin
                idx_d           = '0;
                occ_d[rd_ptr_q] = 1'b0;
                rd_ptr_d        = ~rd_ptr_q;
                cnt_d           = cnt_q + 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // A packet landing in the slot about to be drained is taken straight from the bus.
        sel_pkt = slot_q[rd_ptr_d];
        if (capture && (wr_ptr_q == rd_ptr_d)) begin
            sel_pkt = out;
        end

        tx_valid_d = occ_d[rd_ptr_d];
        tx_data_d  = occ_d[rd_ptr_d] ? sel_pkt[{idx_d, 3'b000} +: 8] : 8'h00;
        tx_last_d  = occ_d[rd_ptr_d] && (idx_d == LastIdx);
        readpkt_d  = (cap_d == CAck);
    end

    // Control state and registered outputs; reset drops any buffered packet.
    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            cap_q      <= CIdle;
            occ_q      <= 2'b00;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            readpkt_q  <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
        end else begin
            cap_q      <= cap_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            readpkt_q  <= readpkt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
        end
    end

    // Packet payload store; validity is tracked by the occupancy flags.
    always_ff @(posedge clk) begin
        if (capture) begin
            slot_q[wr_ptr_q] <= out;
        end
    end

    assign out_readPKT = readpkt_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign tx_last     = tx_last_q;
    assign busy        = |occ_q;
    assign pkt_count   = cnt_q;

endmodule

// File: doc/simon_pkt_serialiser.md
Name: simon_pkt_serialiser

Overview:
- Downstream stage of SIMON_topPKT.
- Consumes each finished ciphertext/plaintext packet presented on the core's parallel output bus through the out_donePKT / out_readPKT handshake.
- Buffers up to two packets in a ping-pong store and streams them out one byte per beat on a valid/ready byte interface, toward the host link.
- Lets the core hand off the next packet while the previous one is still draining.

Parameters:
- N, 96, SIMON block width in bits; sets packet size.
- PKT_BYTES, (N/2)+2 (=50), bytes per packet on the core output bus.
- CNT_W, 16, width of the packet counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- R  in  1  asynchronous active-high reset.
- out  in  PKT_BYTES x 8  packet from core; byte index 0 is transmitted first.
- out_donePKT  in  1  core has a complete packet on out; stays high until acknowledged.
- out_readPKT  out  1  acknowledge to core: packet captured.
- tx_data  out  8  current byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts byte when tx_valid and tx_ready are both high at the clock edge.
- tx_last  out  1  high with the final byte (index PKT_BYTES-1) of a packet.
- busy  out  1  at least one slot occupied.
- pkt_count  out  CNT_W  number of packets fully transmitted; wraps to 0.

Behaviour:
- Interface clocking and reset: one clock, clk. Reset R is asynchronous and active-high.
- Reset values:
  - out_readPKT=0, tx_valid=0, tx_last=0, tx_data=0, busy=0, pkt_count=0.
  - Both slots empty; write pointer=0, read pointer=0, byte index=0, capture FSM in C_IDLE.
  - R asserted mid-packet discards all buffered data immediately (async); no partial packet resumes.
- Storage: two slots of PKT_BYTES bytes, each with an occupied flag. Write pointer selects the capture slot; read pointer selects the draining slot.
- Capture FSM (four-phase handshake with core):
  - C_IDLE: if out_donePKT=1 and the write-pointer slot is empty, latch the whole out bus into that slot, set its occupied flag, toggle the write pointer, go to C_ACK.
    - If both slots are full, stay in C_IDLE, keep out_readPKT=0, and do not sample; the core holds out_donePKT.
  - C_ACK: out_readPKT=1 (registered, first high the cycle after capture). Stay while out_donePKT=1.
  - C_ACK with out_donePKT=0: next cycle out_readPKT=0, go to C_IDLE.
  - No second capture until out_donePKT has been seen low. This prevents double-capture of one packet.
- Transmit path:
  - tx_valid=1 whenever the read-pointer slot is occupied.
  - tx_data = that slot's byte at the byte index (registered mux output, no combinational path from out to tx_data).
  - On a beat (tx_valid & tx_ready): byte index +1.
  - On the beat with index=PKT_BYTES-1:
    - tx_last=1.
    - Byte index returns to 0; slot is cleared, read pointer toggles, pkt_count +1 (mod 2^CNT_W).
    - If the other slot is occupied, tx_valid stays 1 next cycle with its byte 0 (no bubble).
  - tx_valid=1 with tx_ready=0: tx_data/tx_last hold stable; tx_valid never drops until the byte is accepted.
- Latency:
  - Capture edge to tx_valid=1 is 1 cycle when the transmitter is idle.
  - Sustained throughput is 1 byte/cycle with tx_ready=1.
- Simultaneous events:
  - A capture into slot A on the same edge that slot B's last byte is accepted is legal; both updates occur.
  - A capture into the slot just freed on the same edge is not allowed: the occupied flag is sampled pre-edge, so capture waits one cycle.
- busy = OR of occupied flags.

Test Plan:
- Reset: assert R mid-stream with byte 17 of a packet pending -> all outputs 0 within the same cycle, no tx_valid after R releases; pkt_count=0.
- Single packet:
  - Stimulus: load out bytes 0..49 = 8'h00..8'h31, raise out_donePKT, tx_ready=1.
  - Response: out_readPKT high from the cycle after capture until out_donePKT drops, then low.
  - Response: 50 beats 8'h00..8'h31 consecutively, tx_last only on 8'h31, pkt_count=1.
- Back-pressure: toggle tx_ready 1/0 every cycle -> each byte appears exactly once, in order; tx_data stable while tx_ready=0; 50 accepted beats total.
- Ping-pong and full:
  - Stimulus: tx_ready=0, offer three packets P0, P1, P2.
  - Response: P0 and P1 acknowledged; P2's out_donePKT held with out_readPKT=0 and busy=1.
  - Stimulus: raise tx_ready.
  - Response: P0's last beat frees a slot; P2 captured and acknowledged; output order P0, P1, P2 with no idle cycles; pkt_count=3.
- Handshake hold: keep out_donePKT high 10 cycles after capture -> exactly one capture, out_readPKT high 10 cycles, packet transmitted once.
- Counter wrap: preload traffic of 65536 packets (or force CNT_W=4 and send 17) -> pkt_count wraps to 0 then 1; no data corruption across the wrap.
